// File: rtl/lock_code_sender.sv
// Replays a stored key code MSB-first as timed pulses on zero_out/one_out.
// Define LOCK_CODE_SENDER_SEG7_EN to build the bit-index 7-seg decoder.
module lock_code_sender #(
    parameter int                  CODE_LEN   = 5,
    parameter logic [CODE_LEN-1:0] CODE       = 5'b01011,
    parameter int                  TICK_DIV   = 20_000_000,
    parameter int                  HOLD_TICKS = 2,
    parameter int                  GAP_TICKS  = 2
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       start,
    output logic       zero_out,
    output logic       one_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] bit_idx,
    output logic [6:0] seg7,
    output logic [2:0] enable
);

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PMAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HOLD_LAST = PW'(HOLD_TICKS - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_TICKS - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(CODE_LEN - 1);
    localparam logic [7:0]    CODE_W    = 8'(CODE);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

    state_t        state_q;
    logic          s1_q, s2_q, s3_q;
    logic [1:0]    vld_q;
    logic          armed_q;
    logic [TW-1:0] tick_q;
    logic [PW-1:0] phase_q;
    logic [2:0]    bit_idx_q;
    logic          zero_q, one_q, busy_q, done_q;

    logic          accept_d;
    logic          tick_end_d;
    logic [2:0]    next_idx_d;

    function automatic logic code_bit(input logic [2:0] idx);
        return CODE_W[IDX_LAST - idx];
    endfunction

    // armed_q demands a genuine low sample after reset, so a held button never resends
    assign accept_d   = armed_q & s2_q & ~s3_q;
    assign tick_end_d = (tick_q == TICK_LAST);
    assign next_idx_d = bit_idx_q + 3'd1;

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            vld_q     <= 2'b00;
            armed_q   <= 1'b0;
            tick_q    <= '0;
            phase_q   <= '0;
            bit_idx_q <= 3'd0;
            zero_q    <= 1'b0;
            one_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            s1_q    <= start;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & ~s2_q);
            unique case (state_q)
                IDLE: begin
                    tick_q  <= '0;
                    phase_q <= '0;
                    if (accept_d) begin
                        state_q   <= DRIVE;
                        bit_idx_q <= 3'd0;
                        busy_q    <= 1'b1;
                        zero_q    <= ~code_bit(3'd0);
                        one_q     <= code_bit(3'd0);
                    end
                end
                DRIVE: begin
                    if (tick_end_d) begin
                        tick_q <= '0;
                        if (phase_q == HOLD_LAST) begin
                            phase_q <= '0;
                            state_q <= GAP;
                            zero_q  <= 1'b0;
                            one_q   <= 1'b0;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                GAP: begin
                    if (tick_end_d) begin
                        tick_q <= '0;
                        if (phase_q == GAP_LAST) begin
                            phase_q <= '0;
                            if (bit_idx_q == IDX_LAST) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= DRIVE;
                                bit_idx_q <= next_idx_d;
                                zero_q    <= ~code_bit(next_idx_d);
                                one_q     <= code_bit(next_idx_d);
                            end
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    bit_idx_q <= 3'd0;
                    tick_q    <= '0;
                    phase_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign zero_out = zero_q;
    assign one_out  = one_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bit_idx  = bit_idx_q;
    assign enable   = 3'b110;

`ifdef LOCK_CODE_SENDER_SEG7_EN
    logic [6:0] seg7_d;

    always_comb begin
        seg7_d = 7'b0111111;
        if (state_q == DRIVE || state_q == GAP) begin
            unique case (bit_idx_q)
                3'd0: seg7_d = 7'b1000000;
                3'd1: seg7_d = 7'b1111001;
                3'd2: seg7_d = 7'b0100100;
                3'd3: seg7_d = 7'b0110000;
                3'd4: seg7_d = 7'b0011001;
                3'd5: seg7_d = 7'b0010010;
                3'd6: seg7_d = 7'b0000010;
                3'd7: seg7_d = 7'b1111000;
                default: seg7_d = 7'b0111111;
            endcase
        end
    end

    assign seg7 = seg7_d;
`else
    assign seg7 = 7'b1111111;
`endif

endmodule
